// File: rtl/sm2_pkg.sv
// sm2_pkg: widths, counts and FSM state type shared by the SM2 frame loader
// and its length/mask helper.
//   SM2_FRAME_W  full core input frame {k, pbx, pby, l, d, pad}
//   SM2_KEY_W    width of each of k, pbx, pby
//   SM2_LEN_W    width of the l field (one stream word)
//   SM2_MSG_W    width of the d field
//   SM2_PAD_W    zero padding at the bottom of the frame
//   HDR_WORDS    stream words in the header (k, pbx, pby, l)
package sm2_pkg;

  localparam int SM2_FRAME_W = 2048;
  localparam int SM2_KEY_W   = 256;
  localparam int SM2_LEN_W   = 32;
  localparam int SM2_MSG_W   = 1024;
  localparam int SM2_PAD_W   = 224;
  localparam int HDR_WORDS   = 25;
  localparam int HDR_SR_W    = 3 * SM2_KEY_W;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    MSG   = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/sm2_len_mask.sv
// sm2_len_mask: combinational helper for the message length field.
//   len    in   32    message length l in bits
//   mask   out  1024  bit i set when i < len (all ones for len >= 1024)
//   words  out  6     ceil(len/32); meaningful only for len <= 1024
module sm2_len_mask
  import sm2_pkg::*;
(
  input  logic [SM2_LEN_W-1:0] len,
  output logic [SM2_MSG_W-1:0] mask,
  output logic [5:0]           words
);

  // Shifting by >= 1024 yields zero, so oversize lengths give a full mask.
  assign mask  = ~({SM2_MSG_W{1'b1}} << len);
  assign words = len[10:5] + {5'b0, |len[4:0]};

endmodule

// File: rtl/sm2_frame_loader.sv
// sm2_frame_loader: assembles the 2048-bit SM2 core input frame from a 32-bit
// valid/ready word stream and launches the core with a one-cycle start pulse.
// The frame stays on core_din until the core reports a result.
//   clk, rst       clock and synchronous active-high reset
//   s_data/s_valid/s_ready   input word stream
//   mode_dec       operation select, taken with the first header word
//   core_din       frame {k, pbx, pby, l, d_masked, 224'b0}
//   core_decrypt   latched mode_dec
//   core_start     one-cycle start pulse
//   core_valid     core result valid
//   busy           frame in progress
//   frame_done     pulse when the core result arrives in WAIT
//   err_len        pulse when l exceeds MAX_MSG_BITS
//
// state | meaning
// HDR   | collecting the 25 header words (k, pbx, pby, l)
// MSG   | collecting ceil(l/32) message words into d
// START | core_din valid, core_start asserted for this one cycle
// WAIT  | frame held on core_din until core_valid
module sm2_frame_loader
  import sm2_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int MAX_MSG_BITS = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   mode_dec,
  output logic [SM2_FRAME_W-1:0] core_din,
  output logic                   core_decrypt,
  output logic                   core_start,
  input  logic                   core_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_len
);

  state_t                state_q, state_d;
  logic [4:0]            hdr_cnt_q;
  logic [5:0]            msg_cnt_q;
  logic [5:0]            msg_words_q;
  logic [HDR_SR_W-1:0]   hdr_q;
  logic [SM2_LEN_W-1:0]  len_q;
  logic [SM2_MSG_W-1:0]  d_q;
  logic                  dec_q;
  logic                  err_q;

  logic                  xfer;
  logic                  last_hdr;
  logic                  last_msg;
  logic                  len_too_long;
  logic                  len_zero;
  logic [SM2_LEN_W-1:0]  len_sel;
  logic [SM2_MSG_W-1:0]  len_mask;
  logic [5:0]            len_words;

  assign xfer         = s_valid && s_ready;
  assign last_hdr     = (hdr_cnt_q == 5'(HDR_WORDS - 1));
  assign last_msg     = (msg_cnt_q == msg_words_q - 6'd1);
  assign len_too_long = (s_data > 32'(MAX_MSG_BITS));
  assign len_zero     = (s_data == '0);

  // One helper serves both uses: in HDR it sizes the incoming l word,
  // elsewhere it masks d with the stored l.
  assign len_sel = (state_q == HDR) ? s_data : len_q;

  sm2_len_mask u_len_mask (
    .len   (len_sel),
    .mask  (len_mask),
    .words (len_words)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR: begin
        if (xfer && last_hdr) begin
          if (len_too_long)  state_d = HDR;
          else if (len_zero) state_d = START;
          else               state_d = MSG;
        end
      end
      MSG:     if (xfer && last_msg) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (core_valid) state_d = HDR;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR;
      hdr_cnt_q   <= '0;
      msg_cnt_q   <= '0;
      msg_words_q <= '0;
      hdr_q       <= '0;
      len_q       <= '0;
      d_q         <= '0;
      dec_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (xfer && state_q == HDR) begin
        if (hdr_cnt_q == '0) dec_q <= mode_dec;
        if (last_hdr) begin
          hdr_cnt_q   <= '0;
          len_q       <= s_data;
          msg_cnt_q   <= '0;
          msg_words_q <= len_words;
          err_q       <= len_too_long;
        end else begin
          hdr_q     <= {hdr_q[HDR_SR_W-WORD_W-1:0], s_data};
          hdr_cnt_q <= hdr_cnt_q + 5'd1;
        end
      end
      // Words from an earlier, longer frame may linger above the new ones;
      // the length mask removes them from core_din.
      if (xfer && state_q == MSG) begin
        d_q       <= {d_q[SM2_MSG_W-WORD_W-1:0], s_data};
        msg_cnt_q <= msg_cnt_q + 6'd1;
      end
    end
  end

  // s_ready is gated by rst so no word is acknowledged while it is discarded.
  assign s_ready      = !rst && (state_q == HDR || state_q == MSG);
  assign core_start   = (state_q == START);
  assign frame_done   = (state_q == WAIT) && core_valid;
  assign busy         = (state_q != HDR) || (hdr_cnt_q != '0);
  assign err_len      = err_q;
  assign core_decrypt = dec_q;
  assign core_din     = {hdr_q, len_q, d_q & len_mask, {SM2_PAD_W{1'b0}}};

endmodule

// File: tb/tb_sm2_frame_loader.sv
module tb_sm2_frame_loader;
  import sm2_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          mode_dec = 1'b0;
  logic [2047:0] core_din;
  logic          core_decrypt;
  logic          core_start;
  logic          core_valid = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          err_len;

  always #5 clk = ~clk;

  sm2_frame_loader #(.WORD_W(32), .MAX_MSG_BITS(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .mode_dec     (mode_dec),
    .core_din     (core_din),
    .core_decrypt (core_decrypt),
    .core_start   (core_start),
    .core_valid   (core_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_len      (err_len)
  );

  typedef struct {
    logic [255:0]  k;
    logic [255:0]  pbx;
    logic [255:0]  pby;
    logic [31:0]   l;
    logic [1023:0] msg;
    bit            mode;
    bit            gaps;
    int            hold;
    bit            exp_err;
    logic [2047:0] exp_din;
  } vec_t;

  typedef struct {
    logic [2047:0] din;
    bit            dec;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  int   n_start = 0;
  sb_t  sb[$];
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_din(input string name, input logic [2047:0] act, input logic [2047:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      errors++;
      idx = 0;
      for (int i = 63; i >= 0; i--) if (act[32*i +: 32] !== exp[32*i +: 32]) idx = i;
      $display("FAIL %s: word %0d got %08h expected %08h", name, idx,
               act[32*idx +: 32], exp[32*idx +: 32]);
    end
  endtask

  function automatic vec_t mk(input logic [255:0] k, input logic [255:0] pbx,
                              input logic [255:0] pby, input logic [31:0] l,
                              input logic [1023:0] msg, input bit mode, input bit gaps,
                              input int hold, input bit err, input logic [1023:0] d_exp);
    vec_t v;
    v.k = k; v.pbx = pbx; v.pby = pby; v.l = l; v.msg = msg;
    v.mode = mode; v.gaps = gaps; v.hold = hold; v.exp_err = err;
    v.exp_din = {k, pbx, pby, l, d_exp, 224'd0};
    return v;
  endfunction

  // Scoreboard check: every start pulse pops the oldest expected frame.
  always @(negedge clk) begin
    if (core_start) begin
      n_start++;
      if (sb.size() == 0) begin
        chk("unexpected_start", 64'd1, 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk_din("start_din", core_din, e.din);
        chk("start_decrypt", core_decrypt, e.dec);
      end
    end
  end

  task automatic put_word(input logic [31:0] w, input bit mode, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_data = w; s_valid = 1'b1; mode_dec = mode;
    n = 0;
    while (!s_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, input int max_words);
    logic [31:0] w[$];
    int n, lim;
    bit full;
    for (int i = 0; i < 8; i++) w.push_back(v.k[255-32*i -: 32]);
    for (int i = 0; i < 8; i++) w.push_back(v.pbx[255-32*i -: 32]);
    for (int i = 0; i < 8; i++) w.push_back(v.pby[255-32*i -: 32]);
    w.push_back(v.l);
    if (v.l <= 32'd1024) begin
      n = (int'(v.l) + 31) / 32;
      for (int j = n - 1; j >= 0; j--) w.push_back(v.msg[32*j +: 32]);
    end
    full = (max_words >= w.size());
    lim  = full ? w.size() : max_words;
    if (full && !v.exp_err) sb.push_back('{v.exp_din, v.mode});
    // mode_dec toggles after the first word; only the first must be latched.
    for (int i = 0; i < lim; i++) begin
      put_word(w[i], (i == 0) ? v.mode : !v.mode, v.gaps);
      if (i == 0) chk("busy_first_word", busy, 1);
    end
    if (full) begin
      if (v.exp_err) begin
        chk("err_len_pulse", err_len, 1);
        chk("err_no_start", core_start, 0);
        chk("err_busy", busy, 0);
        @(posedge clk); #1;
        chk("err_len_single", err_len, 0);
        chk("err_no_start_later", core_start, 0);
      end else begin
        chk("start_latency", core_start, 1);
      end
    end
  endtask

  task automatic finish_frame(input vec_t v);
    bit bad;
    bad = 1'b0;
    repeat (v.hold) begin
      if (s_ready) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("s_ready_low_in_wait", bad, 0);
    chk_din("din_hold", core_din, v.exp_din);
    chk("decrypt_hold", core_decrypt, v.mode);
    if (v.l == 32'd1024) chk("din_bit1247", core_din[1247], 1);
    core_valid = 1'b1;
    #1;
    chk("frame_done_pulse", frame_done, 1);
    @(posedge clk); #1;
    core_valid = 1'b0;
    chk("s_ready_after_done", s_ready, 1);
    chk("busy_after_done", busy, 0);
    chk("frame_done_single", frame_done, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(256'd6, 256'd0, 256'd0, 32'd37, 1024'h12_3456789A, 1'b0, 1'b0, 2, 1'b0,
                1024'h12_3456789A);
    tbl[1] = mk(256'd6, 256'd0, 256'd0, 32'd37, 1024'hFFFFFFF2_3456789A, 1'b1, 1'b0, 2, 1'b0,
                1024'h12_3456789A);
    tbl[2] = mk({8{32'h1111_1111}}, {8{32'h2222_2222}}, {8{32'h3333_3333}}, 32'd0,
                1024'hABCD, 1'b0, 1'b0, 2, 1'b0, 1024'd0);
    tbl[3] = mk(256'd0, 256'd0, 256'd0, 32'd1024, {32'h8000_0000, {31{32'h0F0F_1234}}},
                1'b1, 1'b0, 2, 1'b0, {32'h8000_0000, {31{32'h0F0F_1234}}});
    tbl[4] = mk(256'd9, 256'd8, 256'd7, 32'd1025, 1024'd0, 1'b1, 1'b0, 0, 1'b1, 1024'd0);
    tbl[5] = tbl[0];
    tbl[6] = mk(256'd6, 256'd0, 256'd0, 32'd37, 1024'h12_3456789A, 1'b0, 1'b1, 100, 1'b0,
                1024'h12_3456789A);
    tbl[7] = mk({8{32'hA5A5_5A5A}}, {8{32'h0123_4567}}, {8{32'h89AB_CDEF}}, 32'd33,
                1024'hFFFFFFFF_DEADBEEF, 1'b1, 1'b1, 3, 1'b0, 1024'h1_DEADBEEF);
    tbl[8] = mk(256'd1, 256'd2, 256'd3, 32'd32, 1024'hCAFEF00D, 1'b0, 1'b0, 2, 1'b0,
                1024'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    chk_din("reset_core_din", core_din, 2048'd0);
    chk("reset_core_start", core_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_err_len", err_len, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_decrypt", core_decrypt, 0);
    rst = 1'b0;
    #1;
    chk("idle_s_ready", s_ready, 1);

    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i], 1000);
      if (!tbl[i].exp_err) finish_frame(tbl[i]);
    end

    // core_valid while idle in HDR must be ignored.
    core_valid = 1'b1;
    #1;
    chk("hdr_core_valid_ignored", frame_done, 0);
    @(posedge clk); #1;
    core_valid = 1'b0;
    chk("hdr_core_valid_busy", busy, 0);
    chk("hdr_core_valid_ready", s_ready, 1);

    // Reset after 30 words (25 header + 5 message) of a decrypt frame.
    send_frame(tbl[3], 30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_din("midreset_core_din", core_din, 2048'd0);
    chk("midreset_core_start", core_start, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_decrypt", core_decrypt, 0);
    chk("midreset_err_len", err_len, 0);
    chk("midreset_s_ready", s_ready, 1);
    send_frame(tbl[0], 1000);
    finish_frame(tbl[0]);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("start_count", n_start, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
